scan_seq_16: RTL and testbench

- Row-scan sequencer that sits directly upstream of the 4-to-16 gate-level decoder and drives its a[3:0] and en inputs.
- Steps through rows 0..15 with a programmable dwell time per row.
- Inserts a programmable blanking gap, with en low, before each row so decoder outputs never overlap or glitch during address changes.
- Supports continuous or one-shot frames, per-row masking and a frame-done pulse.

---
 rtl/scan_pkg.sv | 13 +
 rtl/load_dcnt.sv | 28 ++
 rtl/scan_seq_16.sv | 163 ++++++++++++++++
 tb/tb_scan_seq_16.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and constants for the row-scan sequencer
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam int NUM_ROWS = 16;
  localparam int ROW_W    = 4;

endpackage

// File: rtl/load_dcnt.sv
// rtl/load_dcnt.sv - loadable down-counter with zero flag
module load_dcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load has priority; decrement saturates at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/scan_seq_16.sv
// rtl/scan_seq_16.sv - row-scan sequencer driving a 4-to-16 decoder
module scan_seq_16
  import scan_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int BLANK_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                oneshot,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [BLANK_W-1:0]  blank,
  input  logic [NUM_ROWS-1:0] row_mask,
  output logic [ROW_W-1:0]    a,
  output logic                en,
  output logic                busy,
  output logic                frame_done
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  scan_state_t state, state_n;
  logic [ROW_W-1:0]    row, row_n;
  logic [DWELL_W-1:0]  dwell_sh, eff_dwell, d_val;
  logic [BLANK_W-1:0]  blank_sh, eff_blank, b_val;
  logic [NUM_ROWS-1:0] mask_sh, eff_mask;
  logic                oneshot_sh;
  logic                latch, go_row;
  logic                b_load, b_dec, b_zero;
  logic                d_load, d_dec, d_zero;
  logic [ROW_W-1:0]    a_n;
  logic                en_n, busy_n, fd_n;

  load_dcnt #(.W(BLANK_W)) u_blank_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (b_load),
    .load_val (b_val),
    .dec      (b_dec),
    .zero     (b_zero)
  );

  load_dcnt #(.W(DWELL_W)) u_dwell_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (d_load),
    .load_val (d_val),
    .dec      (d_dec),
    .zero     (d_zero)
  );

  // next state, counter control and next registered outputs
  always_comb begin
    state_n = state;
    row_n   = row;
    latch   = 1'b0;
    go_row  = 1'b0;
    fd_n    = 1'b0;
    b_load  = 1'b0;
    b_dec   = 1'b0;
    b_val   = '0;
    d_load  = 1'b0;
    d_dec   = 1'b0;
    d_val   = '0;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          latch  = 1'b1;
          row_n  = '0;
          go_row = 1'b1;
        end
      end
      BLANK: begin
        if (stop) begin
          state_n = IDLE;
        end else if (b_zero) begin
          state_n = DRIVE;
          d_load  = 1'b1;
          d_val   = dwell_sh;
        end else begin
          b_dec = 1'b1;
        end
      end
      DRIVE: begin
        // stop is checked first so an aborted frame never reports done
        if (stop) begin
          state_n = IDLE;
        end else if (d_zero) begin
          if (row == LAST_ROW) begin
            fd_n = 1'b1;
            if (oneshot_sh) begin
              state_n = IDLE;
            end else begin
              latch  = 1'b1;
              row_n  = '0;
              go_row = 1'b1;
            end
          end else begin
            row_n  = row + ROW_W'(1);
            go_row = 1'b1;
          end
        end else begin
          d_dec = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // on a frame start the fresh inputs apply immediately, not the old shadows
    eff_blank = latch ? blank    : blank_sh;
    eff_dwell = latch ? dwell    : dwell_sh;
    eff_mask  = latch ? row_mask : mask_sh;

    if (go_row) begin
      if (eff_blank != '0) begin
        state_n = BLANK;
        b_load  = 1'b1;
        b_val   = eff_blank - BLANK_W'(1);
      end else begin
        state_n = DRIVE;
        d_load  = 1'b1;
        d_val   = eff_dwell;
      end
    end

    busy_n = (state_n != IDLE);
    en_n   = (state_n == DRIVE) && eff_mask[row_n];
    a_n    = busy_n ? row_n : a;
  end

  // state, row, outputs and config shadows
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      a          <= '0;
      en         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dwell_sh   <= '0;
      blank_sh   <= '0;
      mask_sh    <= '0;
      oneshot_sh <= 1'b0;
    end else begin
      state      <= state_n;
      row        <= row_n;
      a          <= a_n;
      en         <= en_n;
      busy       <= busy_n;
      frame_done <= fd_n;
      if (latch) begin
        dwell_sh   <= dwell;
        blank_sh   <= blank;
        mask_sh    <= row_mask;
        oneshot_sh <= oneshot;
      end
    end
  end

endmodule

// File: tb/tb_scan_seq_16.sv
// tb/tb_scan_seq_16.sv - directed self-checking bench for scan_seq_16
module tb_scan_seq_16;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        oneshot;
  logic [15:0] dwell;
  logic [7:0]  blank;
  logic [15:0] row_mask;
  logic [3:0]  a;
  logic        en;
  logic        busy;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  scan_seq_16 #(.DWELL_W(16), .BLANK_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .oneshot    (oneshot),
    .dwell      (dwell),
    .blank      (blank),
    .row_mask   (row_mask),
    .a          (a),
    .en         (en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ex(input int ea, input bit een, input bit ebusy, input bit efd);
    logic [3:0] a4;
    a4 = ea[3:0];
    return {25'd0, a4, een, ebusy, efd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] expv);
    logic [31:0] obs;
    obs = {25'd0, a, en, busy, frame_done};
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed a/en/busy/fd=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b1;
    dwell = 16'd0; blank = 8'd0; row_mask = 16'h0000;
    #1;
    chk("reset_state", ex(0, 0, 0, 0));
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("idle_after_reset", ex(0, 0, 0, 0));

    // basic timing: 2 blank + 4 drive cycles per row, one frame
    dwell = 16'd3; blank = 8'd2; oneshot = 1'b1; row_mask = 16'hFFFF;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 6; c++) begin
        chk($sformatf("basic_r%0d_c%0d", i, c), ex(i, c >= 2, 1, 0));
        tick();
      end
    end
    chk("basic_frame_done", ex(15, 0, 0, 1));
    tick();
    chk("basic_idle_after", ex(15, 0, 0, 0));

    // masking: only rows 4..7 drive, slot is 2 cycles for every row
    dwell = 16'd0; blank = 8'd1; row_mask = 16'h00F0;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("mask_r%0d_c%0d", i, c), ex(i, (c == 1) && (i >= 4) && (i <= 7), 1, 0));
        tick();
      end
    end
    chk("mask_frame_done", ex(15, 0, 0, 1));

    // continuous wrap; mid-frame mask/oneshot changes wait for the wrap
    dwell = 16'd0; blank = 8'd0; oneshot = 1'b0; row_mask = 16'hFFFF;
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("wrap_f%0d_r%0d", f, i), ex(i, (f < 2) || (i == 0), 1, (f > 0) && (i == 0)));
        if (f == 1 && i == 5) begin
          row_mask = 16'h0001;
          oneshot  = 1'b1;
        end
        tick();
      end
    end
    chk("wrap_last_done", ex(15, 0, 0, 1));
    tick();

    // stop during row 9 drive
    dwell = 16'd2; blank = 8'd1; oneshot = 1'b1; row_mask = 16'hFFFF;
    pulse_start();
    for (int k = 0; k < 37; k++) tick();
    chk("stop_row9_drive", ex(9, 1, 1, 0));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_next_cycle", ex(9, 0, 0, 0));
    tick(); tick();
    chk("stop_stays_idle", ex(9, 0, 0, 0));
    pulse_start();
    chk("restart_row0", ex(0, 0, 1, 0));

    // contention: start and stop together in IDLE
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_in_blank", ex(0, 0, 0, 0));
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", ex(0, 0, 0, 0));
    tick();
    chk("start_stop_idle2", ex(0, 0, 0, 0));

    // start pulsed during row 3 blank is ignored
    dwell = 16'd1; blank = 8'd2; oneshot = 1'b1; row_mask = 16'hFFFF;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("busy_start_r%0d_c%0d", i, c), ex(i, c >= 2, 1, 0));
        if (i == 3 && c == 0) start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    chk("busy_start_done", ex(15, 0, 0, 1));

    // asynchronous reset mid-drive
    dwell = 16'd3; blank = 8'd1; oneshot = 1'b1; row_mask = 16'hFFFF;
    pulse_start();
    for (int k = 0; k < 11; k++) tick();
    chk("pre_reset_drive", ex(2, 1, 1, 0));
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_clear", ex(0, 0, 0, 0));
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_idle", ex(0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
